// File: rtl/serial_addsub_module.sv
// Bit-serial (STEP bits per clock) two's-complement adder/subtractor with optional
// saturation on signed overflow. One operation takes WIDTH/STEP clocks in RUN.
module serial_addsub_module #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             v,
  output logic             c
);

  localparam int unsigned N    = WIDTH / STEP;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_a_msb;
  logic             r_sat;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;

  logic [STEP:0]    w_carry;
  logic [STEP-1:0]  w_chunk;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_sat_val;
  logic [WIDTH-1:0] w_final;
  logic             w_v;

  // Ripple the current low STEP bits; operands shift right so the chunk is always at bit 0.
  always_comb begin
    w_carry    = '0;
    w_chunk    = '0;
    w_carry[0] = r_carry;
    for (int i = 0; i < STEP; i++) begin
      w_chunk[i]     = r_a[i] ^ r_b[i] ^ w_carry[i];
      w_carry[i + 1] = (r_a[i] & r_b[i]) | (w_carry[i] & (r_a[i] ^ r_b[i]));
    end
    w_res = r_res >> STEP;
    for (int i = 0; i < STEP; i++) begin
      w_res[WIDTH - STEP + i] = w_chunk[i];
    end
    // Only meaningful on the MSB chunk, which is the only time it is consumed.
    w_v       = w_carry[STEP] ^ w_carry[STEP-1];
    w_sat_val = r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    w_final   = (r_sat && w_v) ? w_sat_val : w_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_a_msb <= 1'b0;
      r_sat   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      v       <= 1'b0;
      c       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{s}};
            r_a_msb <= a[WIDTH-1];
            r_sat   <= sat;
            r_carry <= s;
            r_cnt   <= '0;
            r_res   <= '0;
            busy    <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_a     <= r_a >> STEP;
          r_b     <= r_b >> STEP;
          r_res   <= w_res;
          r_carry <= w_carry[STEP];
          if (r_cnt == LastCnt) begin
            sum     <= w_final;
            v       <= w_v;
            c       <= w_carry[STEP];
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDone: begin
          done    <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_module.sv
// Directed, table-driven bench for serial_addsub_module (WIDTH=4/STEP=1 and WIDTH=8/STEP=2).
module tb_serial_addsub_module;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic       sat;
    logic [3:0] sum;
    logic       v;
    logic       c;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       s;
  logic       sat;
  logic       busy;
  logic       done;
  logic [3:0] sum;
  logic       v;
  logic       c;

  logic       start_w;
  logic [7:0] a_w;
  logic [7:0] b_w;
  logic       s_w;
  logic       sat_w;
  logic       busy_w;
  logic       done_w;
  logic [7:0] sum_w;
  logic       v_w;
  logic       c_w;

  int n_tests;
  int n_fail;
  vec_t vecs[10];

  serial_addsub_module #(.WIDTH(4), .STEP(1)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .s    (s),
    .sat  (sat),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .v    (v),
    .c    (c)
  );

  serial_addsub_module #(.WIDTH(8), .STEP(2)) u_dut_w (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start_w),
    .a    (a_w),
    .b    (b_w),
    .s    (s_w),
    .sat  (sat_w),
    .busy (busy_w),
    .done (done_w),
    .sum  (sum_w),
    .v    (v_w),
    .c    (c_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one narrow operation; inputs are scrambled right after capture.
  task automatic run4(input vec_t t, input int idx, input bit hold_start);
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    a = t.a; b = t.b; s = t.s; sat = t.sat; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    a = ~t.a; b = ~t.b; s = ~t.s; sat = ~t.sat;
    for (int i = 0; i < 4; i++) begin
      check({nm, "_busy"}, {7'd0, busy}, 8'd1);
      check({nm, "_done_early"}, {7'd0, done}, 8'd0);
      @(negedge clk);
    end
    check({nm, "_done"}, {7'd0, done}, 8'd1);
    check({nm, "_busy_off"}, {7'd0, busy}, 8'd0);
    check({nm, "_sum"}, {4'd0, sum}, {4'd0, t.sum});
    check({nm, "_v"}, {7'd0, v}, {7'd0, t.v});
    check({nm, "_c"}, {7'd0, c}, {7'd0, t.c});
    @(negedge clk);
    check({nm, "_done_pulse"}, {7'd0, done}, 8'd0);
    check({nm, "_idle"}, {7'd0, busy}, 8'd0);
    check({nm, "_sum_hold"}, {4'd0, sum}, {4'd0, t.sum});
    start = 1'b0;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                      input logic tsat, input logic [7:0] esum, input logic ev,
                      input logic ec, input string nm);
    @(negedge clk);
    a_w = ta; b_w = tb; s_w = ts; sat_w = tsat; start_w = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_w = 1'b0;
    a_w = ~ta; b_w = ~tb;
    for (int i = 0; i < 4; i++) begin
      check({nm, "_busy"}, {7'd0, busy_w}, 8'd1);
      @(negedge clk);
    end
    check({nm, "_done"}, {7'd0, done_w}, 8'd1);
    check({nm, "_sum"}, sum_w, esum);
    check({nm, "_v"}, {7'd0, v_w}, {7'd0, ev});
    check({nm, "_c"}, {7'd0, c_w}, {7'd0, ec});
    @(negedge clk);
    check({nm, "_done_pulse"}, {7'd0, done_w}, 8'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //            a        b        s     sat   sum      v     c
    vecs[0] = '{4'b0001, 4'b0011, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0};
    vecs[1] = '{4'b0100, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1};
    vecs[2] = '{4'b0010, 4'b0100, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b0};
    vecs[3] = '{4'b0100, 4'b0110, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0};
    vecs[4] = '{4'b0100, 4'b0110, 1'b0, 1'b1, 4'b0111, 1'b1, 1'b0};
    vecs[5] = '{4'b1100, 4'b1010, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b1};
    vecs[6] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[7] = '{4'b1111, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
    vecs[8] = '{4'b1000, 4'b0001, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1};
    vecs[9] = '{4'b1100, 4'b1010, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; s = 1'b0; sat = 1'b0;
    start_w = 1'b0; a_w = '0; b_w = '0; s_w = 1'b0; sat_w = 1'b0;
    #12;
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_sum", {4'd0, sum}, 8'd0);
    check("rst_vc", {6'd0, v, c}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run4(vecs[i], i, 1'b0);

    // start held high through RUN and DONE must not queue a second operation
    run4(vecs[1], 20, 1'b1);
    @(negedge clk);
    check("hold_no_queue", {7'd0, busy}, 8'd0);

    // reset mid-operation: outputs clear asynchronously, no done follows
    @(negedge clk);
    a = 4'b0101; b = 4'b0001; s = 1'b0; sat = 1'b0; start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_done", {7'd0, done}, 8'd0);
    check("abort_sum", {4'd0, sum}, 8'd0);
    check("abort_vc", {6'd0, v, c}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", {7'd0, done}, 8'd0);
      check("abort_no_busy", {7'd0, busy}, 8'd0);
    end

    // first start after reset is accepted immediately
    run4(vecs[0], 30, 1'b0);

    run8(8'h64, 8'h32, 1'b0, 1'b0, 8'h96, 1'b1, 1'b0, "w_add");
    run8(8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, "w_sat_neg");
    run8(8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, "w_sub");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub_module.md
SERIAL_ADDSUB_MODULE -- requirements
Module: serial_addsub_module

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter STEP, default 1: bits processed per clock; SHALL divide WIDTH exactly; N = WIDTH/STEP.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 a  input  WIDTH  first operand, two's complement.
REQ-007 b  input  WIDTH  second operand, two's complement.
REQ-008 s  input  1  mode: 0 = a+b, 1 = a-b.
REQ-009 sat  input  1  1 = saturate the result on signed overflow.
REQ-010 busy  output  1  high while the operation is in RUN.
REQ-011 done  output  1  one-cycle pulse when sum/v/c are updated.
REQ-012 sum  output  WIDTH  registered result.
REQ-013 v  output  1  signed overflow flag for the last operation.
REQ-014 c  output  1  carry out of the MSB for the last operation; for subtraction, 1 = no borrow.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-016 IDLE with start=1 at an edge: capture a, b^{WIDTH{s}}, s and sat; set carry = s; clear the chunk counter; go to RUN.
REQ-017 IDLE with start=0: stay in IDLE; outputs hold.
REQ-018 RUN: each edge adds the next STEP bits (LSB chunk first) of captured a, inverted-b and carry; stores the STEP result bits; propagates the carry.
REQ-019 RUN lasts exactly N edges; the edge that processes the MSB chunk moves the FSM to DONE and loads sum, v and c.
REQ-020 DONE SHALL last one cycle and then go to IDLE unconditionally.
REQ-021 Latency: for start sampled at edge T0, done=1 during the cycle after edge T0+N; the next start is accepted at edge T0+N+2 at the earliest.
REQ-022 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; they are never high together.
REQ-023 start during RUN or DONE SHALL be ignored and not queued.
REQ-024 Changes on a, b, s or sat after capture SHALL NOT affect the operation in progress.
REQ-025 c = carry out of bit WIDTH-1; v = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-026 If sat=1 and v=1: sum = 2^(WIDTH-1)-1 when the captured a[WIDTH-1]=0, else sum = -2^(WIDTH-1); v and c still report the raw values.
REQ-027 If sat=0 or v=0: sum = raw result modulo 2^WIDTH.
REQ-028 sum, v and c SHALL hold their values until the next DONE entry or reset.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, sum=0, v=0, c=0 and clear internal carry, counter and operand registers.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse follows for it.
REQ-031 After rst_n rises, the first start is accepted at the first edge where start=1.

Verification (WIDTH=4, STEP=1 unless stated; done is checked in the cycle after edge T0+4)
REQ-032 a=0001, b=0011, s=0, sat=0 -> sum=0100, v=0, c=0; busy high for 4 cycles, then done high for 1 cycle.
REQ-033 a=0100, b=0010, s=1 -> sum=0010, v=0, c=1; then a=0010, b=0100, s=1 -> sum=1110, v=0, c=0.
REQ-034 a=0100, b=0110, s=0 -> sat=0: sum=1010, v=1, c=0; sat=1: sum=0111, v=1, c=0.
REQ-035 a=1100, b=1010, s=0 -> sat=0: sum=0110, v=1, c=1; sat=1: sum=1000, v=1, c=1.
REQ-036 Start an operation, pulse rst_n low at edge T0+2 -> busy, done, sum, v and c are 0 immediately and no done pulse follows; start held high during RUN is ignored.
REQ-037 WIDTH=8, STEP=2: a=0x64, b=0x32, s=0 -> sum=0x96, v=1, c=0, with done in the cycle after edge T0+4.
